// File: rtl/miriscv_imm_stage.sv
// miriscv_imm_stage: registered immediate/shamt extraction with a skid-buffered valid/ready pipeline register
module miriscv_imm_stage #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] imm_o,
  output logic [2:0]      imm_type_o,
  output logic [SHW-1:0]  shamt_o,
  output logic            illegal_o,
  output logic [XLEN-1:0] pc_o
);
  localparam logic [2:0] T_NONE = 3'd0, T_I = 3'd1, T_S = 3'd2, T_B = 3'd3, T_U = 3'd4, T_J = 3'd5, T_Z = 3'd6;
  localparam logic [4:0] OP_OPIMM = 5'b00100, OP_OPIMM32 = 5'b00110;
  localparam int PW = 2 * XLEN + SHW + 4;
  logic [4:0]      w_op;
  logic [2:0]      w_f3;
  logic [2:0]      w_type;
  logic [XLEN-1:0] w_imm;
  logic            w_sh_f3;
  logic            w_shift;
  logic            w_ill;
  logic [SHW-1:0]  w_shamt;
  logic [PW-1:0]   w_pay;
  logic [PW-1:0]   r_m_pay;
  logic [PW-1:0]   r_k_pay;
  logic            r_m_valid;
  logic            r_k_valid;
  logic            w_unused;
  assign w_op     = instr_i[6:2];
  assign w_f3     = instr_i[14:12];
  assign w_unused = &instr_i[1:0];
  always_comb begin
    w_type = T_NONE;
    case (w_op)
      5'b00100, 5'b00000, 5'b11001, 5'b00110: w_type = T_I;
      5'b01000:                               w_type = T_S;
      5'b11000:                               w_type = T_B;
      5'b01101, 5'b00101:                     w_type = T_U;
      5'b11011:                               w_type = T_J;
      5'b11100:                               w_type = instr_i[14] ? T_Z : T_NONE;
      default:                                w_type = T_NONE;
    endcase
  end
  always_comb begin
    w_imm = (w_type == T_I) ? XLEN'($signed(instr_i[31:20])) :
            (w_type == T_S) ? XLEN'($signed({instr_i[31:25], instr_i[11:7]})) :
            (w_type == T_B) ? XLEN'($signed({instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0})) :
            (w_type == T_U) ? XLEN'($signed({instr_i[31:12], 12'b0})) :
            (w_type == T_J) ? XLEN'($signed({instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0})) :
            (w_type == T_Z) ? XLEN'(instr_i[19:15]) : '0;
  end
  assign w_sh_f3 = (w_f3 == 3'b001) || (w_f3 == 3'b101);
  assign w_shift = ((w_op == OP_OPIMM) && w_sh_f3) || (w_op == OP_OPIMM32);
  assign w_shamt = w_shift ? instr_i[20 +: SHW] : '0;
  // RV32 has no *W shifts at all; on RV64 only a 6-bit shamt on a *W shift is out of range
  assign w_ill = (XLEN == 32) ? (((w_op == OP_OPIMM) && w_sh_f3 && instr_i[25]) || (w_op == OP_OPIMM32))
                              : ((w_op == OP_OPIMM32) && w_sh_f3 && instr_i[25]);
  assign w_pay = {w_imm, w_type, w_shamt, w_ill, pc_i};
  assign in_ready_o  = !r_k_valid;
  assign out_valid_o = r_m_valid;
  assign {imm_o, imm_type_o, shamt_o, illegal_o, pc_o} = r_m_pay;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_m_valid <= 1'b0;
      r_k_valid <= 1'b0;
      r_m_pay   <= '0;
      r_k_pay   <= '0;
    end else if (flush_i) begin
      r_m_valid <= 1'b0;
      r_k_valid <= 1'b0;
    end else if (r_k_valid) begin
      if (out_ready_i) begin
        r_m_pay   <= r_k_pay;
        r_k_valid <= 1'b0;
      end
    end else if (!r_m_valid || out_ready_i) begin
      r_m_valid <= in_valid_i;
      if (in_valid_i) r_m_pay <= w_pay;
    end else if (in_valid_i) begin
      r_k_valid <= 1'b1;
      r_k_pay   <= w_pay;
    end
  end
endmodule

// File: tb/tb_miriscv_imm_stage.sv
// tb_miriscv_imm_stage: directed vectors against RV32 and RV64 instances plus pipeline corner-case sequences
module tb_miriscv_imm_stage;
  typedef struct {
    logic [31:0] instr;
    logic [63:0] imm;
    logic [2:0]  ty;
    logic [5:0]  sh32;
    logic [5:0]  sh64;
    logic        il32;
    logic        il64;
  } vec_t;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] instr = '0;
  logic [63:0] pc = '0;
  logic        rdy32, val32, ill32, rdy64, val64, ill64;
  logic [31:0] imm32, pc32;
  logic [63:0] imm64, pc64;
  logic [2:0]  ty32, ty64;
  logic [4:0]  sh32;
  logic [5:0]  sh64;
  int n_vec = 0;
  int n_bad = 0;
  vec_t v[19];
  always #5 clk = ~clk;
  miriscv_imm_stage #(.XLEN(32)) u32 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(rdy32),
    .instr_i(instr), .pc_i(pc[31:0]), .out_valid_o(val32), .out_ready_i(out_ready),
    .imm_o(imm32), .imm_type_o(ty32), .shamt_o(sh32), .illegal_o(ill32), .pc_o(pc32)
  );
  miriscv_imm_stage #(.XLEN(64)) u64 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(rdy64),
    .instr_i(instr), .pc_i(pc), .out_valid_o(val64), .out_ready_i(out_ready),
    .imm_o(imm64), .imm_type_o(ty64), .shamt_o(sh64), .illegal_o(ill64), .pc_o(pc64)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    n_vec++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  task automatic st(input string t, input logic ev, input logic er, input logic [63:0] ep);
    chk({t, " valid32"}, 64'(val32), 64'(ev));
    chk({t, " valid64"}, 64'(val64), 64'(ev));
    chk({t, " ready32"}, 64'(rdy32), 64'(er));
    chk({t, " ready64"}, 64'(rdy64), 64'(er));
    if (ev) begin
      chk({t, " pc32"}, 64'(pc32), ep & 64'hFFFF_FFFF);
      chk({t, " pc64"}, pc64, ep);
    end
  endtask
  task automatic rz(input string t);
    st(t, 1'b0, 1'b1, '0);
    chk({t, " imm32"}, 64'(imm32), '0);
    chk({t, " imm64"}, imm64, '0);
    chk({t, " type"}, 64'({ty32, ty64}), '0);
    chk({t, " shamt"}, 64'({sh32, sh64}), '0);
    chk({t, " ill"}, 64'({ill32, ill64}), '0);
    chk({t, " pc"}, 64'(pc32) | pc64, '0);
  endtask
  initial begin
    v[0]  = '{32'h123450B7, 64'h0000_0000_1234_5000, 3'd4, 6'd0,  6'd0,  1'b0, 1'b0};
    v[1]  = '{32'h800000B7, 64'hFFFF_FFFF_8000_0000, 3'd4, 6'd0,  6'd0,  1'b0, 1'b0};
    v[2]  = '{32'hFE000EE3, 64'hFFFF_FFFF_FFFF_FFFC, 3'd3, 6'd0,  6'd0,  1'b0, 1'b0};
    v[3]  = '{32'h03F09093, 64'd63,                  3'd1, 6'd31, 6'd63, 1'b1, 1'b0};
    v[4]  = '{32'h3402D073, 64'd5,                   3'd6, 6'd0,  6'd0,  1'b0, 1'b0};
    v[5]  = '{32'h00000073, 64'd0,                   3'd0, 6'd0,  6'd0,  1'b0, 1'b0};
    v[6]  = '{32'hFE20AC23, 64'hFFFF_FFFF_FFFF_FFF8, 3'd2, 6'd0,  6'd0,  1'b0, 1'b0};
    v[7]  = '{32'h0100006F, 64'd16,                  3'd5, 6'd0,  6'd0,  1'b0, 1'b0};
    v[8]  = '{32'hFFDFF0EF, 64'hFFFF_FFFF_FFFF_FFFC, 3'd5, 6'd0,  6'd0,  1'b0, 1'b0};
    v[9]  = '{32'hFFF12083, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 6'd0,  6'd0,  1'b0, 1'b0};
    v[10] = '{32'h01F0909B, 64'd31,                  3'd1, 6'd31, 6'd31, 1'b1, 1'b0};
    v[11] = '{32'h4200D09B, 64'h420,                 3'd1, 6'd0,  6'd32, 1'b1, 1'b1};
    v[12] = '{32'h4050D093, 64'h405,                 3'd1, 6'd5,  6'd5,  1'b0, 1'b0};
    v[13] = '{32'h02008093, 64'd32,                  3'd1, 6'd0,  6'd0,  1'b0, 1'b0};
    v[14] = '{32'hFFFFF097, 64'hFFFF_FFFF_FFFF_F000, 3'd4, 6'd0,  6'd0,  1'b0, 1'b0};
    v[15] = '{32'h34011073, 64'd0,                   3'd0, 6'd0,  6'd0,  1'b0, 1'b0};
    v[16] = '{32'h0000000F, 64'd0,                   3'd0, 6'd0,  6'd0,  1'b0, 1'b0};
    v[17] = '{32'hFFC08067, 64'hFFFF_FFFF_FFFF_FFFC, 3'd1, 6'd0,  6'd0,  1'b0, 1'b0};
    v[18] = '{32'h7FF00013, 64'h7FF,                 3'd1, 6'd0,  6'd0,  1'b0, 1'b0};
    in_valid = 1'b1;
    instr = 32'h123450B7;
    pc = 64'h44;
    tick();
    tick();
    rz("reset");
    rst = 1'b0;
    in_valid = 1'b0;
    tick();
    for (int i = 0; i < 19; i++) begin
      instr = v[i].instr;
      pc = 64'h1000 + 64'(i) * 4;
      in_valid = 1'b1;
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      st($sformatf("v%0d", i), 1'b1, 1'b1, pc);
      chk($sformatf("v%0d imm32", i), 64'(imm32), {32'b0, v[i].imm[31:0]});
      chk($sformatf("v%0d imm64", i), imm64, v[i].imm);
      chk($sformatf("v%0d type32", i), 64'(ty32), 64'(v[i].ty));
      chk($sformatf("v%0d type64", i), 64'(ty64), 64'(v[i].ty));
      chk($sformatf("v%0d shamt32", i), 64'(sh32), 64'(v[i].sh32));
      chk($sformatf("v%0d shamt64", i), 64'(sh64), 64'(v[i].sh64));
      chk($sformatf("v%0d ill32", i), 64'(ill32), 64'(v[i].il32));
      chk($sformatf("v%0d ill64", i), 64'(ill64), 64'(v[i].il64));
    end
    tick();
    st("idle", 1'b0, 1'b1, '0);
    out_ready = 1'b0;
    in_valid = 1'b1;
    instr = 32'h123450B7;
    pc = 64'h0;
    tick();
    st("bp0", 1'b1, 1'b1, 64'h0);
    instr = 32'h800000B7;
    pc = 64'h4;
    tick();
    st("bp1", 1'b1, 1'b0, 64'h0);
    instr = 32'h3402D073;
    pc = 64'h8;
    tick();
    st("bp2", 1'b1, 1'b0, 64'h0);
    chk("bp2 hold imm64", imm64, 64'h1234_5000);
    out_ready = 1'b1;
    tick();
    st("bp3", 1'b1, 1'b1, 64'h4);
    chk("bp3 imm64", imm64, 64'hFFFF_FFFF_8000_0000);
    tick();
    in_valid = 1'b0;
    st("bp4", 1'b1, 1'b1, 64'h8);
    chk("bp4 imm64", imm64, 64'd5);
    tick();
    st("bp5", 1'b0, 1'b1, '0);
    out_ready = 1'b0;
    in_valid = 1'b1;
    pc = 64'h10;
    tick();
    pc = 64'h14;
    tick();
    st("fl_fill", 1'b1, 1'b0, 64'h10);
    flush = 1'b1;
    pc = 64'h18;
    tick();
    st("fl0", 1'b0, 1'b1, '0);
    pc = 64'h1C;
    tick();
    flush = 1'b0;
    st("fl1", 1'b0, 1'b1, '0);
    pc = 64'h20;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    st("fl2", 1'b1, 1'b1, 64'h20);
    tick();
    st("fl3", 1'b0, 1'b1, '0);
    out_ready = 1'b0;
    in_valid = 1'b1;
    instr = 32'h03F09093;
    pc = 64'h30;
    tick();
    pc = 64'h34;
    tick();
    st("rm_fill", 1'b1, 1'b0, 64'h30);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    rz("rmid");
    instr = 32'h123450B7;
    pc = 64'h40;
    in_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    st("post", 1'b1, 1'b1, 64'h40);
    chk("post imm32", 64'(imm32), 64'h1234_5000);
    chk("post type64", 64'(ty64), 64'd4);
    tick();
    st("post_idle", 1'b0, 1'b1, '0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
